// File: rtl/chronox_top.sv
// 24-hour clock with alarm: debounced keys, HH:MM:SS + alarm time, 8-digit muxed display, buzzer.
// Build option: define HOURLY_CHIME_EN for a 1 s tone when MM:SS reaches 00:00 in RUN.
module chronox_top #(
    parameter int CLK_FREQ    = 50000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int SCAN_US     = 1000,
    parameter int ALARM_SECS  = 30,
    parameter int BUZ_HZ      = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [6:0] seg,
    output logic [7:0] sel,
    output logic [2:0] led,
    output logic [2:0] sel_led,
    output logic       buz
);
    localparam int DB_CYC   = int'((longint'(CLK_FREQ) * DEBOUNCE_MS) / 1000);
    localparam int SCAN_CYC = int'((longint'(CLK_FREQ) * SCAN_US) / 1000000);
    localparam int HALF_SEC = CLK_FREQ / 2;
    localparam int BUZ_HALF = CLK_FREQ / (2 * BUZ_HZ);
    localparam int DIV_W    = $clog2(CLK_FREQ);
    localparam int DB_W     = $clog2(DB_CYC + 1);
    localparam int SCAN_W   = $clog2(SCAN_CYC + 1);
    localparam int BUZ_W    = $clog2(BUZ_HALF + 1);
    localparam int RS_W     = $clog2(ALARM_SECS + 1);
    localparam int K_MODE = 0, K_INC = 1, K_NEXT = 2, K_ALARM = 3;

    typedef enum logic [1:0] {M_RUN, M_SET_TIME, M_SET_ALARM} mode_e;
    typedef enum logic [1:0] {F_H, F_M, F_S} fld_e;

    logic [3:0]            sy1_q, sy2_q, db_q, db_d, press_q;
    logic [3:0][DB_W-1:0]  dbc_q, dbc_d;
    mode_e                 mode_q, mode_d;
    fld_e                  fld_q, fld_d;
    logic [4:0]            hh_q, hh_d, ah_q, ah_d, dh;
    logic [5:0]            mm_q, mm_d, ss_q, ss_d, am_q, am_d, as_q, as_d, dm, ds, dv;
    logic                  al_en_q, al_en_d, ring_q, ring_d, tick, trig, gate, dash, blank;
    logic [DIV_W-1:0]      div_q, div_d, blink_q, blink_d, rcyc_q, rcyc_d;
    logic [RS_W-1:0]       rsec_q, rsec_d;
    logic [BUZ_W-1:0]      tcnt_q, tcnt_d;
    logic                  tone_q, tone_d, tone_act, buz_q, buz_d;
    logic [SCAN_W-1:0]     scnt_q, scnt_d;
    logic [2:0]            dig_q, dig_d;
    logic [7:0]            sel_q;
    logic [6:0]            seg_q, seg_d;

    function automatic logic [6:0] hex7(input logic [5:0] v);
        case (v)
            6'd0: hex7 = 7'h3F;  6'd1: hex7 = 7'h06;  6'd2: hex7 = 7'h5B;
            6'd3: hex7 = 7'h4F;  6'd4: hex7 = 7'h66;  6'd5: hex7 = 7'h6D;
            6'd6: hex7 = 7'h7D;  6'd7: hex7 = 7'h07;  6'd8: hex7 = 7'h7F;
            6'd9: hex7 = 7'h6F;  default: hex7 = 7'h00;
        endcase
    endfunction

    // A change is accepted only after the synchronized level differs for DB_CYC cycles in a row.
    always_comb begin
        db_d  = db_q;
        dbc_d = dbc_q;
        for (int i = 0; i < 4; i++) begin
            if (sy2_q[i] == db_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DB_W'(DB_CYC - 1)) begin
                dbc_d[i] = '0;
                db_d[i]  = sy2_q[i];
            end else begin
                dbc_d[i] = dbc_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        mode_d = mode_q;  fld_d = fld_q;   al_en_d = al_en_q;
        hh_d = hh_q;  mm_d = mm_q;  ss_d = ss_q;
        ah_d = ah_q;  am_d = am_q;  as_d = as_q;
        ring_d = ring_q;  rcyc_d = rcyc_q;  rsec_d = rsec_q;
        tick = 1'b0;  trig = 1'b0;
        div_d = div_q + 1'b1;
        if (mode_q == M_SET_TIME) begin
            div_d = '0;
        end else if (div_q == DIV_W'(CLK_FREQ - 1)) begin
            div_d = '0;
            tick  = 1'b1;
        end
        if (tick) begin
            if (ss_q == 6'd59) begin
                ss_d = '0;
                if (mm_q == 6'd59) begin
                    mm_d = '0;
                    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 1'b1;
                end else begin
                    mm_d = mm_q + 1'b1;
                end
            end else begin
                ss_d = ss_q + 1'b1;
            end
            trig = al_en_q && hh_d == ah_q && mm_d == am_q && ss_d == as_q;
        end
        if (ring_q) begin
            if (rcyc_q == DIV_W'(CLK_FREQ - 1)) begin
                rcyc_d = '0;
                if (rsec_q == RS_W'(ALARM_SECS - 1)) ring_d = 1'b0;
                else rsec_d = rsec_q + 1'b1;
            end else begin
                rcyc_d = rcyc_q + 1'b1;
            end
        end
        // While ringing, any press only silences; otherwise presses apply in MODE>NEXT>INC>ALARM order.
        if (|press_q) begin
            if (ring_q) begin
                ring_d = 1'b0;
            end else begin
                if (press_q[K_MODE]) begin
                    fld_d = F_H;
                    case (mode_q)
                        M_RUN:      mode_d = M_SET_TIME;
                        M_SET_TIME: mode_d = M_SET_ALARM;
                        default:    mode_d = M_RUN;
                    endcase
                end
                if (press_q[K_NEXT] && mode_d != M_RUN) begin
                    case (fld_d)
                        F_H:     fld_d = F_M;
                        F_M:     fld_d = F_S;
                        default: fld_d = F_H;
                    endcase
                end
                if (press_q[K_INC] && mode_d == M_SET_TIME) begin
                    case (fld_d)
                        F_H:     hh_d = (hh_d == 5'd23) ? 5'd0 : hh_d + 1'b1;
                        F_M:     mm_d = (mm_d == 6'd59) ? 6'd0 : mm_d + 1'b1;
                        default: ss_d = (ss_d == 6'd59) ? 6'd0 : ss_d + 1'b1;
                    endcase
                end else if (press_q[K_INC] && mode_d == M_SET_ALARM) begin
                    case (fld_d)
                        F_H:     ah_d = (ah_q == 5'd23) ? 5'd0 : ah_q + 1'b1;
                        F_M:     am_d = (am_q == 6'd59) ? 6'd0 : am_q + 1'b1;
                        default: as_d = (as_q == 6'd59) ? 6'd0 : as_q + 1'b1;
                    endcase
                end
                if (press_q[K_ALARM]) al_en_d = ~al_en_q;
            end
        end
        if (mode_d == M_SET_TIME) div_d = '0;
        if (trig) begin
            ring_d = 1'b1;
            rcyc_d = '0;
            rsec_d = '0;
        end
    end

    assign gate = rcyc_q < DIV_W'(HALF_SEC);
`ifdef HOURLY_CHIME_EN
    logic             chime_q, chime_start;
    logic [DIV_W-1:0] chc_q;
    assign chime_start = tick && mode_q == M_RUN && mm_d == 6'd0 && ss_d == 6'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chime_q <= 1'b0;
            chc_q   <= '0;
        end else if (chime_start) begin
            chime_q <= 1'b1;
            chc_q   <= '0;
        end else if (chime_q) begin
            if (chc_q == DIV_W'(CLK_FREQ - 1)) chime_q <= 1'b0;
            chc_q <= chc_q + 1'b1;
        end
    end
    assign tone_act = ring_q | chime_q;
    assign buz_d    = ring_q ? (gate & tone_q) : (chime_q & tone_q);
`else
    assign tone_act = ring_q;
    assign buz_d    = ring_q & gate & tone_q;
`endif

    always_comb begin
        tcnt_d = '0;
        tone_d = 1'b0;
        if (tone_act) begin
            tone_d = tone_q;
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_q == BUZ_W'(BUZ_HALF - 1)) begin
                tcnt_d = '0;
                tone_d = ~tone_q;
            end
        end
    end

    always_comb begin
        dh = (mode_q == M_SET_ALARM) ? ah_q : hh_q;
        dm = (mode_q == M_SET_ALARM) ? am_q : mm_q;
        ds = (mode_q == M_SET_ALARM) ? as_q : ss_q;
        dash = 1'b0;
        dv   = '0;
        case (dig_q)
            3'd0:    dv = {1'b0, dh} / 6'd10;
            3'd1:    dv = {1'b0, dh} % 6'd10;
            3'd3:    dv = dm / 6'd10;
            3'd4:    dv = dm % 6'd10;
            3'd6:    dv = ds / 6'd10;
            3'd7:    dv = ds % 6'd10;
            default: dash = 1'b1;
        endcase
        blank = mode_q != M_RUN && blink_q >= DIV_W'(HALF_SEC / 2) &&
                ((fld_q == F_H && dig_q <= 3'd1) || (fld_q == F_M && (dig_q == 3'd3 || dig_q == 3'd4)) ||
                 (fld_q == F_S && dig_q >= 3'd6));
        if (blank)     seg_d = 7'h00;
        else if (dash) seg_d = (dig_q == 3'd5 && mode_q == M_RUN && al_en_q) ? 7'b1000001 : 7'b1000000;
        else           seg_d = hex7(dv);
        scnt_d  = scnt_q + 1'b1;
        dig_d   = dig_q;
        if (scnt_q == SCAN_W'(SCAN_CYC - 1)) begin
            scnt_d = '0;
            dig_d  = dig_q + 1'b1;
        end
        blink_d = (blink_q == DIV_W'(HALF_SEC - 1)) ? '0 : blink_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sy1_q <= 4'hF;  sy2_q <= 4'hF;  db_q <= 4'hF;  press_q <= '0;  dbc_q <= '0;
            mode_q <= M_RUN;  fld_q <= F_H;  al_en_q <= 1'b0;
            hh_q <= '0;  mm_q <= '0;  ss_q <= '0;
            ah_q <= 5'd7;  am_q <= '0;  as_q <= '0;
            div_q <= '0;  blink_q <= '0;  rcyc_q <= '0;  rsec_q <= '0;  ring_q <= 1'b0;
            tcnt_q <= '0;  tone_q <= 1'b0;  buz_q <= 1'b0;
            scnt_q <= '0;  dig_q <= '0;  sel_q <= 8'hFF;  seg_q <= '0;
        end else begin
            sy1_q <= key_in;  sy2_q <= sy1_q;  db_q <= db_d;  dbc_q <= dbc_d;
            press_q <= db_q & ~db_d;
            mode_q <= mode_d;  fld_q <= fld_d;  al_en_q <= al_en_d;
            hh_q <= hh_d;  mm_q <= mm_d;  ss_q <= ss_d;
            ah_q <= ah_d;  am_q <= am_d;  as_q <= as_d;
            div_q <= div_d;  blink_q <= blink_d;  rcyc_q <= rcyc_d;  rsec_q <= rsec_d;  ring_q <= ring_d;
            tcnt_q <= tcnt_d;  tone_q <= tone_d;  buz_q <= buz_d;
            scnt_q <= scnt_d;  dig_q <= dig_d;  sel_q <= ~(8'h80 >> dig_q);  seg_q <= seg_d;
        end
    end

    assign seg     = seg_q;
    assign sel     = sel_q;
    assign buz     = buz_q;
    assign led     = (mode_q == M_SET_TIME) ? 3'b010 : (mode_q == M_SET_ALARM) ? 3'b100 : 3'b001;
    assign sel_led = (mode_q == M_RUN) ? 3'b000 : (fld_q == F_H) ? 3'b100 : (fld_q == F_M) ? 3'b010 : 3'b001;
endmodule

// File: tb/tb_chronox_top.sv
// Directed bench for chronox_top with scaled-down rates: 4 kHz clock, 8-cycle debounce,
// 4-cycle digit dwell, 0.5 s = 2000 cycles, 8-cycle buzzer half period, 2 s alarm.
module tb_chronox_top;
    typedef logic [7:0][6:0] disp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [6:0] seg;
    logic [7:0] sel;
    logic [2:0] led, sel_led;
    logic       buz;
    int         checks = 0, passed = 0;
    disp_t      dispv, expv;
    logic       rd_ok;

    localparam int K_MODE = 0, K_INC = 1, K_NEXT = 2, K_ALARM = 3;

    chronox_top #(.CLK_FREQ(4000), .DEBOUNCE_MS(2), .SCAN_US(1000), .ALARM_SECS(2), .BUZ_HZ(250)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .seg(seg), .sel(sel),
        .led(led), .sel_led(sel_led), .buz(buz)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] bseg(input int d);
        case (d)
            0: bseg = 7'h3F;  1: bseg = 7'h06;  2: bseg = 7'h5B;  3: bseg = 7'h4F;  4: bseg = 7'h66;
            5: bseg = 7'h6D;  6: bseg = 7'h7D;  7: bseg = 7'h07;  8: bseg = 7'h7F;  default: bseg = 7'h6F;
        endcase
    endfunction

    function automatic disp_t exp_disp(input int h, input int m, input int s, input logic [6:0] d5);
        disp_t r;
        r[0] = bseg(h / 10);  r[1] = bseg(h % 10);  r[2] = 7'h40;
        r[3] = bseg(m / 10);  r[4] = bseg(m % 10);  r[5] = d5;
        r[6] = bseg(s / 10);  r[7] = bseg(s % 10);
        return r;
    endfunction

    task automatic press(input int k, input int hold, input int rel);
        @(negedge clk);
        key_in[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key_in[k] = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    task automatic press_n(input int k, input int n);
        for (int i = 0; i < n; i++) press(k, 24, 24);
    endtask

    task automatic read_disp();
        logic [7:0] want;
        int n;
        rd_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = 8'h80 >> k;
            want = ~want;
            n = 0;
            while (sel !== want && n < 200) begin @(negedge clk); n++; end
            if (sel !== want) rd_ok = 1'b0;
            dispv[k] = seg;
        end
    endtask

    task automatic read_unblanked();
        int n = 0;
        do begin read_disp(); n++; end while ((dispv[3] == 7'h00 || dispv[4] == 7'h00) && n < 150);
    endtask

    task automatic test_reset();
        logic [7:0] s0, s1;
        int n;
        rst = 1'b1;  key_in = 4'hF;
        repeat (4) @(negedge clk);
        checks++; if (sel !== 8'hFF) $display("FAIL rst_sel: got %h expected ff", sel); else passed++;
        checks++; if (seg !== 7'h00) $display("FAIL rst_seg: got %h expected 00", seg); else passed++;
        checks++; if (led !== 3'b001) $display("FAIL rst_led: got %b expected 001", led); else passed++;
        checks++; if (sel_led !== 3'b000) $display("FAIL rst_sel_led: got %b expected 000", sel_led); else passed++;
        checks++; if (buz !== 1'b0) $display("FAIL rst_buz: got %b expected 0", buz); else passed++;
        rst = 1'b0;
        read_disp();
        expv = exp_disp(0, 0, 0, 7'h40);
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL disp_reset: got %h expected %h ok=%0d", dispv, expv, rd_ok); else passed++;
        checks++; if (led !== 3'b001 || sel_led !== 3'b000 || buz !== 1'b0)
            $display("FAIL idle_outs: got led=%b sel_led=%b buz=%b expected 001/000/0", led, sel_led, buz); else passed++;
        s0 = sel;  n = 0;
        while (sel === s0 && n < 100) begin @(negedge clk); n++; end
        s1 = sel;  n = 0;
        while (sel === s1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n !== 4) $display("FAIL scan_dwell: got %0d cycles expected 4", n); else passed++;
        checks++; if (sel !== {s1[0], s1[7:1]}) $display("FAIL scan_order: got %h expected %h", sel, {s1[0], s1[7:1]}); else passed++;
    endtask

    task automatic test_run_keys();
        press(K_INC, 4, 40);
        press(K_INC, 24, 24);
        press(K_NEXT, 24, 24);
        checks++; if (led !== 3'b001 || sel_led !== 3'b000)
            $display("FAIL run_keys_mode: got led=%b sel_led=%b expected 001/000", led, sel_led); else passed++;
        read_disp();
        expv = exp_disp(0, 0, 0, 7'h40);
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL run_keys_disp: got %h expected %h", dispv, expv); else passed++;
    endtask

    task automatic test_set_time();
        int n;
        press(K_MODE, 24, 24);
        checks++; if (led !== 3'b010 || sel_led !== 3'b100)
            $display("FAIL set_enter: got led=%b sel_led=%b expected 010/100", led, sel_led); else passed++;
        press(K_NEXT, 24, 24);
        checks++; if (sel_led !== 3'b010) $display("FAIL set_next: got %b expected 010", sel_led); else passed++;
        press_n(K_INC, 3);
        press(K_INC, 4, 40);
        read_unblanked();
        expv = exp_disp(0, 3, 0, 7'h40);
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL set_inc3: got %h expected %h", dispv, expv); else passed++;
        n = 0;
        do begin read_disp(); n++; end while ((dispv[3] !== 7'h00 || dispv[4] !== 7'h00) && n < 150);
        checks++; if (dispv[3] !== 7'h00 || dispv[4] !== 7'h00 || dispv[0] !== 7'h3F)
            $display("FAIL set_blink: got %h expected minutes blanked", dispv); else passed++;
        repeat (4500) @(negedge clk);
        read_unblanked();
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL set_frozen: got %h expected %h", dispv, expv); else passed++;
        press_n(K_NEXT, 2);
        press_n(K_INC, 23);
        press(K_NEXT, 24, 24);
        press_n(K_INC, 56);
        press(K_NEXT, 24, 24);
        press_n(K_INC, 58);
        checks++; if (sel_led !== 3'b001) $display("FAIL set_sec_field: got %b expected 001", sel_led); else passed++;
        press_n(K_MODE, 2);
        read_disp();
        expv = exp_disp(23, 59, 58, 7'h40);
        checks++; if (!rd_ok || dispv !== expv || led !== 3'b001)
            $display("FAIL set_result: got %h led=%b expected %h led=001", dispv, led, expv); else passed++;
        repeat (8000) @(negedge clk);
        read_disp();
        expv = exp_disp(0, 0, 0, 7'h40);
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL day_wrap: got %h expected %h", dispv, expv); else passed++;
    endtask

    task automatic test_alarm();
        int n;
        logic bad;
        press_n(K_MODE, 2);
        checks++; if (led !== 3'b100) $display("FAIL alarm_mode: got %b expected 100", led); else passed++;
        press_n(K_INC, 17);
        press_n(K_NEXT, 2);
        press_n(K_INC, 3);
        press(K_MODE, 24, 24);
        press(K_ALARM, 24, 24);
        read_disp();
        expv = exp_disp(0, 0, 0, 7'h41);
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL alarm_en_disp: got %h expected %h", dispv, expv); else passed++;
        checks++; if (buz !== 1'b0) $display("FAIL alarm_pre_buz: got %b expected 0", buz); else passed++;
        n = 0;
        while (buz !== 1'b1 && n < 14000) begin @(negedge clk); n++; end
        checks++; if (buz !== 1'b1 || n < 9000) $display("FAIL alarm_start: buz=%b after %0d cycles expected 1 after >=9000", buz, n); else passed++;
        n = 0;
        while (buz === 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n !== 8) $display("FAIL tone_high: got %0d cycles expected 8", n); else passed++;
        n = 0;
        while (buz === 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n !== 8) $display("FAIL tone_low: got %0d cycles expected 8", n); else passed++;
        repeat (2100) @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin @(negedge clk); if (buz !== 1'b0) bad = 1'b1; end
        checks++; if (bad) $display("FAIL gate_off: got buz active expected 0 in off window"); else passed++;
        repeat (1500) @(negedge clk);
        n = 0;
        while (buz !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (buz !== 1'b1) $display("FAIL gate_on: got %b expected 1 in second on window", buz); else passed++;
        press(K_ALARM, 24, 24);
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (buz !== 1'b0) bad = 1'b1; end
        checks++; if (bad) $display("FAIL silence: got buz active expected 0"); else passed++;
        read_disp();
        expv = exp_disp(0, 0, 4, 7'h41);
        checks++; if (!rd_ok || dispv !== expv) $display("FAIL silence_keeps_en: got %h expected %h", dispv, expv); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic bad;
        press_n(K_MODE, 2);
        press_n(K_NEXT, 2);
        press_n(K_INC, 3);
        press(K_MODE, 24, 24);
        n = 0;
        while (buz !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        checks++; if (buz !== 1'b1) $display("FAIL ring2_start: got %b expected 1", buz); else passed++;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (sel !== 8'hFF || seg !== 7'h00 || buz !== 1'b0 || led !== 3'b001 || sel_led !== 3'b000)
            $display("FAIL mid_rst: got sel=%h seg=%h buz=%b led=%b sel_led=%b expected ff/00/0/001/000",
                     sel, seg, buz, led, sel_led); else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        read_disp();
        expv = exp_disp(0, 0, 0, 7'h40);
        checks++; if (!rd_ok || dispv !== expv || led !== 3'b001)
            $display("FAIL post_rst: got %h led=%b expected %h led=001", dispv, led, expv); else passed++;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (buz !== 1'b0) bad = 1'b1; end
        checks++; if (bad) $display("FAIL post_rst_buz: got buz active expected 0"); else passed++;
    endtask

    initial begin
        test_reset();
        test_run_keys();
        test_set_time();
        test_alarm();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/chronox_top.md
Name: chronox_top

Overview:
- Top level of a 24-hour digital clock with alarm on a 50 MHz board.
- Debounces four active-low push-buttons and keeps HH:MM:SS time plus an alarm time.
- Drives an 8-digit multiplexed 7-segment display, three mode LEDs, three field-select LEDs and a buzzer.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- DEBOUNCE_MS, 10, key stable time in ms before a state change is accepted.
- SCAN_US, 1000, dwell time per display digit in µs.
- ALARM_SECS, 30, alarm ring duration in seconds.
- BUZ_HZ, 2000, buzzer tone frequency in Hz.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  4  push-buttons, active-low (0 = pressed): [0] MODE, [1] INC, [2] NEXT, [3] ALARM.
- seg  out  7  segments, active-high, seg[0]=a … seg[6]=g.
- sel  out  8  digit enables, active-low one-cold; sel[7] = leftmost digit.
- led  out  3  mode indicator, one-hot: [0] RUN, [1] SET_TIME, [2] SET_ALARM.
- sel_led  out  3  edited field, one-hot: [2] hours, [1] minutes, [0] seconds; 000 in RUN.
- buz  out  1  buzzer drive, active-high.

Behaviour:
- Reset (asynchronous, while rst=1):
  - time = 00:00:00; alarm = 07:00:00; alarm_en = 0; mode = RUN; field = hours.
  - Outputs: sel = 8'hFF, seg = 0, led = 001, sel_led = 000, buz = 0.
  - All prescalers and debouncers cleared.
- Keys:
  - Each key passes through a 2-flop synchronizer.
  - The debounced level changes only after the raw level has been stable for DEBOUNCE_MS × CLK_FREQ/1000 cycles.
  - A one-clock press pulse is generated on the debounced 1→0 edge. Holding a key produces no repeat.
  - A press shorter than DEBOUNCE_MS produces no pulse.
  - Simultaneous presses are all processed in the same cycle, in priority MODE > NEXT > INC > ALARM.
- 1 Hz tick: divider of CLK_FREQ cycles.
  - Seconds and minutes wrap 59→0 with carry; hours wrap 23→0.
  - Time counts in RUN and SET_ALARM.
  - Time is frozen in SET_TIME, and the divider is cleared on entering SET_TIME.
- Modes:
  - MODE press cycles RUN→SET_TIME→SET_ALARM→RUN and resets field to hours.
  - NEXT (set modes only) cycles hours→minutes→seconds→hours.
  - INC (set modes only) increments the selected field of the displayed value (time or alarm), modulo 24/60, with no carry into other fields. INC and NEXT are ignored in RUN.
- ALARM key:
  - If the buzzer is ringing, it silences the buzzer only.
  - Otherwise it toggles alarm_en.
- Any key press while ringing silences the buzzer; the press is consumed and has no other effect.
- Alarm triggers when alarm_en=1 and time becomes equal to alarm on a 1 Hz tick.
  - It rings for ALARM_SECS seconds.
  - buz = BUZ_HZ square wave, gated on for 0.5 s and off for 0.5 s.
- Display:
  - Digits, left to right: H1 H0 '-' M1 M0 '-' S1 S0. The dash is seg g only.
  - Shows the time in RUN/SET_TIME and the alarm in SET_ALARM.
  - One digit is active per SCAN_US; order sel[7]→sel[0], then repeats.
  - In set modes the selected field's two digits are blanked (seg=0) for the second half of each 0.5 s period (2 Hz blink).
  - In RUN, the rightmost dash shows segment g plus a (seg = 7'b1000001) when alarm_en = 1.
  - Hex patterns are standard for 0–9; seg for other values = 0.
- All state registers update on the clk rising edge; no combinational path from key_in to outputs.

Optional Feature:
- HOURLY_CHIME_EN defined: when a RUN-mode 1 Hz tick makes MM:SS = 00:00, buz outputs a continuous BUZ_HZ tone for 1 s. An active alarm has priority; the chime is not silenced by keys.
- Not defined: no chime logic, and buz depends only on the alarm.

Test Plan:
- Reset pulse, then idle 5 ms → sel cycles through 8 one-cold values at 1 ms each; digits read 00-00-00; led=001, sel_led=000, buz=0.
- RUN mode, press INC (key_in=1101) for 5 ms, release 10 ms, press 20 ms, release 20 ms → no change to time or mode; display still 00-00-00 and no pulse on the 5 ms glitch.
- MODE press of 20 ms → led=010, sel_led=100. Then NEXT 20 ms → sel_led=010. Then three INC presses of 20 ms (released 20 ms between) → minutes = 03, hours/seconds unchanged, time frozen.
- From 23:59:58 in RUN, wait 2 s → 00:00:00.
- Set alarm to current time + 2 s, enable with ALARM, wait → buz toggles at 2 kHz within the gated window. Then press ALARM → buz=0 and alarm_en stays 1.
- Assert rst mid-scan and mid-ring → all outputs immediately take their reset values; after release, time = 00:00:00 and mode = RUN.
